// File: rtl/spi_req_sched.sv
`timescale 1ns/1ps
// spi_req_sched: round-robin arbiter that shares one SPI core's APB slave
// port among NREQ requesters. For each winner it selects the slave, writes
// one TX frame, polls STATUS until RX data is present, reads it back and
// returns it with a one-cycle done pulse. A one-time CTRL1 write follows reset.
module spi_req_sched #(
    parameter int          NREQ       = 2,
    parameter int          APB_DWIDTH = 8,
    parameter logic [7:0]  CTRL1_INIT = 8'h03,
    parameter int          TIMEOUT    = 255
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic [NREQ-1:0]            req,
    input  logic [3*NREQ-1:0]          req_ssel,
    input  logic [APB_DWIDTH*NREQ-1:0] req_txdata,
    output logic [NREQ-1:0]            done,
    output logic [APB_DWIDTH-1:0]      rsp_rdata,
    output logic                       rsp_err,
    output logic                       busy,
    output logic [6:0]                 PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [APB_DWIDTH-1:0]      PWDATA,
    input  logic [APB_DWIDTH-1:0]      PRDATA
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [6:0] A_CTRL1  = 7'h00;
    localparam logic [6:0] A_RXDATA = 7'h08;
    localparam logic [6:0] A_TXDATA = 7'h0C;
    localparam logic [6:0] A_STATUS = 7'h20;
    localparam logic [6:0] A_SSEL   = 7'h24;

    // Phase of an APB transfer within a state: 0 = not started (INIT only),
    // 1 = SETUP, 2 = ACCESS.
    localparam logic [1:0] PH_NONE   = 2'd0;
    localparam logic [1:0] PH_SETUP  = 2'd1;
    localparam logic [1:0] PH_ACCESS = 2'd2;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_ARB, S_WSSEL, S_WTX, S_POLL, S_RDRX, S_DONE
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [1:0]              r_phase, w_phase_nxt;
    logic [NREQ-1:0]         r_reqs;
    logic [GW-1:0]           r_grant, w_grant_nxt;    // doubles as last_grant
    logic [2:0]              r_ssel, w_ssel_nxt;
    logic [APB_DWIDTH-1:0]   r_txdata, w_txdata_nxt;
    logic [7:0]              r_cnt, w_cnt_nxt;
    logic [APB_DWIDTH-1:0]   r_rdata, w_rdata_nxt;
    logic                    r_err, w_err_nxt;
    logic [GW-1:0]           w_arb_idx;
    logic                    w_arb_found;

    logic [NREQ-1:0]         r_done, w_done_nxt;
    logic                    r_busy, w_busy_nxt;
    logic [6:0]              r_paddr, w_paddr_nxt;
    logic                    r_psel, w_psel_nxt;
    logic                    r_penable, w_penable_nxt;
    logic                    r_pwrite, w_pwrite_nxt;
    logic [APB_DWIDTH-1:0]   r_pwdata, w_pwdata_nxt;

    // Candidate index for the off-th step of a search starting after last.
    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] last, input int off);
        int s;
        s = (int'(last) + 1 + off) % NREQ;
        return GW'(s);
    endfunction

    // Round-robin search over the requests captured when leaving IDLE.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = r_grant;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_arb_found && r_reqs[rr_idx(r_grant, i)]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = rr_idx(r_grant, i);
            end else begin
                w_arb_found = w_arb_found;
            end
        end
    end

    // Next-state logic and per-transaction bookkeeping.
    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_grant_nxt  = r_grant;
        w_ssel_nxt   = r_ssel;
        w_txdata_nxt = r_txdata;
        w_cnt_nxt    = r_cnt;
        w_rdata_nxt  = r_rdata;
        w_err_nxt    = r_err;
        case (r_state)
            S_INIT: begin
                if (r_phase == PH_ACCESS) begin
                    w_state_nxt = S_IDLE;
                    w_phase_nxt = PH_NONE;
                end else begin
                    w_phase_nxt = r_phase + 2'd1;
                end
            end
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_ARB;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ARB: begin
                w_state_nxt  = S_WSSEL;
                w_phase_nxt  = PH_SETUP;
                w_cnt_nxt    = 8'd0;
                if (w_arb_found) begin
                    w_grant_nxt  = w_arb_idx;
                    w_ssel_nxt   = req_ssel[3*int'(w_arb_idx) +: 3];
                    w_txdata_nxt = req_txdata[APB_DWIDTH*int'(w_arb_idx) +: APB_DWIDTH];
                end else begin
                    w_grant_nxt  = r_grant;
                end
            end
            S_WSSEL, S_WTX: begin
                if (r_phase == PH_ACCESS) begin
                    w_state_nxt = (r_state == S_WSSEL) ? S_WTX : S_POLL;
                    w_phase_nxt = PH_SETUP;
                end else begin
                    w_phase_nxt = PH_ACCESS;
                end
            end
            S_POLL: begin
                if (r_phase != PH_ACCESS) begin
                    w_phase_nxt = PH_ACCESS;
                end else if (!PRDATA[2]) begin
                    w_state_nxt = S_RDRX;
                    w_phase_nxt = PH_SETUP;
                end else if ((r_cnt + 8'd1) == 8'(TIMEOUT)) begin
                    // Slave never produced data: give up with an error.
                    w_cnt_nxt   = r_cnt + 8'd1;
                    w_state_nxt = S_DONE;
                    w_phase_nxt = PH_NONE;
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                    w_phase_nxt = PH_SETUP;
                end
            end
            S_RDRX: begin
                if (r_phase == PH_ACCESS) begin
                    w_state_nxt = S_DONE;
                    w_phase_nxt = PH_NONE;
                    w_rdata_nxt = PRDATA;
                    w_err_nxt   = 1'b0;
                end else begin
                    w_phase_nxt = PH_ACCESS;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_phase_nxt = PH_NONE;
            end
            default: begin
                w_state_nxt = S_INIT;
                w_phase_nxt = PH_NONE;
            end
        endcase
    end

    // Output decode from the next state so outputs register in step with it.
    always_comb begin
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_pwrite_nxt  = 1'b0;
        w_paddr_nxt   = 7'h00;
        w_pwdata_nxt  = '0;
        w_busy_nxt    = (w_state_nxt != S_IDLE);
        w_done_nxt    = '0;
        case (w_state_nxt)
            S_INIT: begin
                if (w_phase_nxt != PH_NONE) begin
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = (w_phase_nxt == PH_ACCESS);
                    w_pwrite_nxt  = 1'b1;
                    w_paddr_nxt   = A_CTRL1;
                    w_pwdata_nxt  = APB_DWIDTH'(CTRL1_INIT);
                end else begin
                    w_psel_nxt    = 1'b0;
                end
            end
            S_WSSEL: begin
                w_psel_nxt    = 1'b1;
                w_penable_nxt = (w_phase_nxt == PH_ACCESS);
                w_pwrite_nxt  = 1'b1;
                w_paddr_nxt   = A_SSEL;
                w_pwdata_nxt  = {{(APB_DWIDTH-1){1'b0}}, 1'b1} << w_ssel_nxt;
            end
            S_WTX: begin
                w_psel_nxt    = 1'b1;
                w_penable_nxt = (w_phase_nxt == PH_ACCESS);
                w_pwrite_nxt  = 1'b1;
                w_paddr_nxt   = A_TXDATA;
                w_pwdata_nxt  = w_txdata_nxt;
            end
            S_POLL: begin
                w_psel_nxt    = 1'b1;
                w_penable_nxt = (w_phase_nxt == PH_ACCESS);
                w_paddr_nxt   = A_STATUS;
            end
            S_RDRX: begin
                w_psel_nxt    = 1'b1;
                w_penable_nxt = (w_phase_nxt == PH_ACCESS);
                w_paddr_nxt   = A_RXDATA;
            end
            S_DONE: begin
                w_done_nxt = {{(NREQ-1){1'b0}}, 1'b1} << w_grant_nxt;
            end
            default: begin
                w_psel_nxt = 1'b0;
            end
        endcase
    end

    // State, transaction context and registered outputs.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state   <= S_INIT;
            r_phase   <= PH_NONE;
            r_reqs    <= '0;
            r_grant   <= GW'(NREQ - 1);
            r_ssel    <= 3'd0;
            r_txdata  <= '0;
            r_cnt     <= 8'd0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_done    <= '0;
            r_busy    <= 1'b0;
            r_paddr   <= 7'h00;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_reqs    <= (r_state == S_IDLE) ? req : r_reqs;
            r_grant   <= w_grant_nxt;
            r_ssel    <= w_ssel_nxt;
            r_txdata  <= w_txdata_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rdata   <= w_rdata_nxt;
            r_err     <= w_err_nxt;
            r_done    <= w_done_nxt;
            r_busy    <= w_busy_nxt;
            r_paddr   <= w_paddr_nxt;
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
            r_pwrite  <= w_pwrite_nxt;
            r_pwdata  <= w_pwdata_nxt;
        end
    end

    assign done      = r_done;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign busy      = r_busy;
    assign PADDR     = r_paddr;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;

endmodule

// File: tb/tb_spi_req_sched.sv
`timescale 1ns/1ps
// Scoreboard bench for spi_req_sched: a behavioural SPI APB slave answers
// STATUS/RXDATA reads; expected APB transfers and responses are queued when
// a request is issued and consumed as the DUT produces them.
module tb_spi_req_sched;
    localparam int NREQ = 2;
    localparam int DW   = 8;
    localparam int TMO  = 4;

    logic            PCLK = 1'b0;
    logic            PRESET = 1'b1;
    logic [1:0]      req = 2'b00;
    logic [5:0]      req_ssel = 6'd0;
    logic [15:0]     req_txdata = 16'd0;
    logic [1:0]      done;
    logic [7:0]      rsp_rdata;
    logic            rsp_err;
    logic            busy;
    logic [6:0]      PADDR;
    logic            PSEL, PENABLE, PWRITE;
    logic [7:0]      PWDATA;
    logic [7:0]      PRDATA;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    logic [31:0] apb_q[$];
    logic [31:0] rsp_q[$];

    // Slave model state
    int          busy_set = 0;
    int          status_reads = 0;
    logic [7:0]  last_tx = 8'h00;

    spi_req_sched #(.NREQ(NREQ), .APB_DWIDTH(DW), .CTRL1_INIT(8'h03), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_ssel(req_ssel),
        .req_txdata(req_txdata), .done(done), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    // STATUS reports rxempty for the first busy_set polls; RX returns tx^0x99.
    assign PRDATA = (PADDR == 7'h20) ? ((status_reads < busy_set) ? 8'h04 : 8'h00) :
                    (PADDR == 7'h08) ? (last_tx ^ 8'h99) : 8'h00;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Slave register side effects at the end of each ACCESS cycle.
    always @(posedge PCLK) begin
        if (!PRESET && PSEL && PENABLE) begin
            if (PWRITE && PADDR == 7'h0C) last_tx <= PWDATA;
            if (PWRITE && PADDR == 7'h24) status_reads <= 0;
            if (!PWRITE && PADDR == 7'h20) status_reads <= status_reads + 1;
        end
    end

    // Monitor: compare every APB transfer and every done pulse with the scoreboard.
    always @(negedge PCLK) begin
        if (!PRESET) begin
            if (PSEL && PENABLE) begin
                if (apb_q.size() == 0)
                    check_val("apb_unexpected", 32'(apb_q.size()), 32'd1);
                else
                    check_val("apb_xfer", 32'({PWRITE, PADDR, PWDATA}), apb_q.pop_front());
            end
            if (!PSEL && (PENABLE || PWRITE || PADDR != 7'h00 || PWDATA != 8'h00))
                check_val("apb_idle", 32'({PENABLE, PWRITE, PADDR, PWDATA}), 32'd0);
            if (done != 2'b00) begin
                done_cnt++;
                if (rsp_q.size() == 0)
                    check_val("done_unexpected", 32'(rsp_q.size()), 32'd1);
                else
                    check_val("rsp", 32'({done, rsp_err, rsp_rdata}), rsp_q.pop_front());
            end
        end
    end

    task automatic push_xact(input int idx, input logic [2:0] ssel, input logic [7:0] tx,
                             input int nbusy, input bit tmo);
        int np;
        logic [1:0] oh;
        logic [7:0] one;
        one = 8'd1;
        apb_q.push_back(32'({1'b1, 7'h24, one << ssel}));
        apb_q.push_back(32'({1'b1, 7'h0C, tx}));
        np = tmo ? TMO : nbusy + 1;
        for (int k = 0; k < np; k++) apb_q.push_back(32'({1'b0, 7'h20, 8'h00}));
        if (!tmo) apb_q.push_back(32'({1'b0, 7'h08, 8'h00}));
        oh = 2'b01 << idx;
        rsp_q.push_back(32'({oh, tmo, (tmo ? 8'h00 : (tx ^ 8'h99))}));
    endtask

    task automatic do_req(input int idx, input logic [2:0] ssel, input logic [7:0] tx,
                          input int nbusy, input bit tmo, input int exp_lat);
        int n;
        bit seen;
        repeat (3) @(negedge PCLK);
        busy_set = nbusy;
        req_ssel[idx*3 +: 3] = ssel;
        req_txdata[idx*8 +: 8] = tx;
        push_xact(idx, ssel, tx, nbusy, tmo);
        req[idx] = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            @(posedge PCLK);
            n++;
            #1;
            if (done != 2'b00) seen = 1'b1;
        end
        check_val("done_seen", 32'(seen), 32'd1);
        check_val("latency", 32'(n), 32'(exp_lat));
        @(negedge PCLK);
        req[idx] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn, n, last_t, dc0;
        bit hit;

        repeat (3) @(negedge PCLK);
        check_val("reset_outs", 32'({PSEL, PENABLE, PWRITE, PADDR, PWDATA, done, rsp_err, busy}), 32'd0);
        check_val("reset_rdata", 32'(rsp_rdata), 32'd0);

        // Init sequence
        apb_q.push_back(32'({1'b1, 7'h00, 8'h03}));
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        check_val("init_setup", 32'({PSEL, PENABLE, busy}), 32'b101);
        @(posedge PCLK); #1;
        check_val("init_access", 32'({PSEL, PENABLE}), 32'b11);
        @(posedge PCLK); #1;
        check_val("init_busy", 32'(busy), 32'd0);

        // Single request, fast slave
        do_req(0, 3'd5, 8'hA5, 0, 1'b0, 10);
        check_val("hold_rdata", 32'({rsp_err, rsp_rdata}), 32'h03C);
        // Slow slave: three busy polls
        do_req(0, 3'd3, 8'h11, 3, 1'b0, 16);
        // Timeout on requester 1
        do_req(1, 3'd6, 8'h77, 1000, 1'b1, 6 + 2*TMO);
        check_val("hold_err", 32'({rsp_err, rsp_rdata}), 32'h100);

        // Round-robin with both requests held continuously
        repeat (3) @(negedge PCLK);
        busy_set = 0;
        req_ssel = {3'd2, 3'd5};
        req_txdata = {8'h5A, 8'hA5};
        push_xact(0, 3'd5, 8'hA5, 0, 1'b0);
        push_xact(1, 3'd2, 8'h5A, 0, 1'b0);
        push_xact(0, 3'd5, 8'hA5, 0, 1'b0);
        push_xact(1, 3'd2, 8'h5A, 0, 1'b0);
        req = 2'b11;
        dn = 0; n = 0; last_t = 0;
        while (dn < 4 && n < 300) begin
            @(posedge PCLK);
            n++;
            #1;
            if (done != 2'b00) begin
                if (dn > 0) check_val("b2b_gap", 32'(n - last_t), 32'd11);
                last_t = n;
                dn++;
            end
        end
        check_val("rr_done_count", 32'(dn), 32'd4);
        @(negedge PCLK);
        req = 2'b00;

        // Reset during the WTX access cycle
        repeat (3) @(negedge PCLK);
        req_ssel[2:0] = 3'd1;
        req_txdata[7:0] = 8'h3C;
        push_xact(0, 3'd1, 8'h3C, 0, 1'b0);
        req[0] = 1'b1;
        hit = 1'b0; n = 0;
        while (!hit && n < 50) begin
            @(posedge PCLK);
            n++;
            #2;
            if (PSEL && PENABLE && PADDR == 7'h0C) hit = 1'b1;
        end
        check_val("wtx_reached", 32'(hit), 32'd1);
        PRESET = 1'b1;
        #1;
        check_val("rst_apb", 32'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 32'd0);
        check_val("rst_busy_done", 32'({busy, done}), 32'd0);
        apb_q.delete();
        rsp_q.delete();
        req = 2'b00;
        dc0 = done_cnt;
        @(negedge PCLK);
        apb_q.push_back(32'({1'b1, 7'h00, 8'h03}));
        PRESET = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        check_val("reinit_busy", 32'(busy), 32'd0);
        repeat (20) @(posedge PCLK);
        check_val("no_done_after_rst", 32'(done_cnt - dc0), 32'd0);

        check_val("apb_q_empty", 32'(apb_q.size()), 32'd0);
        check_val("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
